// File: rtl/lcd_hd44780_responder.sv
// Device-side model of an 8-bit HD44780 panel: decodes bus transfers into a 2x16 DDRAM,
// models busy timing, answers status/data reads and records sticky protocol errors.
module lcd_hd44780_responder #(
    parameter int unsigned BUSY_CYCLES  = 40,
    parameter int unsigned CLEAR_CYCLES = 1600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lcd_rs,
    input  logic        lcd_rw,
    input  logic        lcd_en,
    input  logic [7:0]  lcd_data_in,
    output logic [7:0]  lcd_data_out,
    output logic        lcd_data_oe,
    output logic        busy,
    output logic [6:0]  ac,
    output logic        disp_on,
    output logic [3:0]  err,
    output logic [15:0] cmd_count,
    input  logic [4:0]  rd_addr,
    output logic [7:0]  rd_char
);

    localparam logic [11:0] BusyLoad  = 12'(BUSY_CYCLES);
    localparam logic [11:0] ClearLoad = 12'(CLEAR_CYCLES);

    logic        en_q;
    logic        cap_rs_q;
    logic        cap_rw_q;
    logic [7:0]  cap_data_q;
    logic [11:0] busy_cnt_q;
    logic [6:0]  ac_q;
    logic        id_q;
    logic        disp_on_q;
    logic [3:0]  err_q;
    logic [15:0] cmd_count_q;
    logic [7:0]  ddram_q [32];
    logic        commit;

    // Lines 0 and 1 occupy 0x00-0x0F and 0x40-0x4F; bit 6 selects the line.
    function automatic logic visible(input logic [6:0] a);
        return a[5:4] == 2'b00;
    endfunction

    function automatic logic [6:0] step(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a == 7'h0F) return 7'h40;
            if (a == 7'h4F) return 7'h00;
            return a + 7'd1;
        end
        if (a == 7'h00) return 7'h4F;
        if (a == 7'h40) return 7'h0F;
        return a - 7'd1;
    endfunction

    assign commit = en_q & ~lcd_en;

    always_ff @(posedge clk) begin
        if (!rst) begin
            en_q        <= 1'b0;
            cap_rs_q    <= 1'b0;
            cap_rw_q    <= 1'b0;
            cap_data_q  <= 8'h00;
            busy_cnt_q  <= 12'd0;
            ac_q        <= 7'h00;
            id_q        <= 1'b1;
            disp_on_q   <= 1'b0;
            err_q       <= 4'h0;
            cmd_count_q <= 16'h0000;
            for (int i = 0; i < 32; i++) ddram_q[i] <= 8'h20;
        end else begin
            en_q <= lcd_en;
            if (lcd_en) begin
                cap_rs_q <= lcd_rs;
                cap_rw_q <= lcd_rw;
                if (!lcd_rw) cap_data_q <= lcd_data_in;
            end
            if (busy_cnt_q != 12'd0) busy_cnt_q <= busy_cnt_q - 12'd1;

            if (commit) begin
                if (cap_rw_q) begin
                    // Status reads have no side effects; data reads advance ac.
                    if (cap_rs_q) begin
                        if (busy_cnt_q != 12'd0) err_q[0] <= 1'b1;
                        else ac_q <= step(ac_q, id_q);
                    end
                end else if (!cap_rs_q && cap_data_q == 8'h00) begin
                    // Null instruction: nothing happens.
                end else if (busy_cnt_q != 12'd0) begin
                    err_q[0] <= 1'b1;
                end else begin
                    busy_cnt_q <= BusyLoad;
                    if (cmd_count_q != 16'hFFFF) cmd_count_q <= cmd_count_q + 16'd1;
                    if (cap_rs_q) begin
                        if (visible(ac_q)) ddram_q[{ac_q[6], ac_q[3:0]}] <= cap_data_q;
                        else err_q[2] <= 1'b1;
                        ac_q <= step(ac_q, id_q);
                    end else begin
                        casez (cap_data_q)
                            8'b1???????: begin
                                ac_q <= cap_data_q[6:0];
                                if (!visible(cap_data_q[6:0])) err_q[2] <= 1'b1;
                            end
                            8'b01??????: err_q[3] <= 1'b1;
                            8'b001?????: begin
                                if (!cap_data_q[4] || !cap_data_q[3]) err_q[1] <= 1'b1;
                            end
                            8'b0001????: begin
                                if (cap_data_q[3]) err_q[1] <= 1'b1;
                                else ac_q <= step(ac_q, cap_data_q[2]);
                            end
                            8'b00001???: disp_on_q <= cap_data_q[2];
                            8'b000001??: begin
                                id_q <= cap_data_q[1];
                                if (cap_data_q[0]) err_q[1] <= 1'b1;
                            end
                            8'b0000001?: begin
                                ac_q       <= 7'h00;
                                busy_cnt_q <= ClearLoad;
                            end
                            default: begin
                                ac_q       <= 7'h00;
                                id_q       <= 1'b1;
                                busy_cnt_q <= ClearLoad;
                                for (int i = 0; i < 32; i++) ddram_q[i] <= 8'h20;
                            end
                        endcase
                    end
                end
            end
        end
    end

    always_comb begin
        lcd_data_oe  = lcd_en & lcd_rw;
        lcd_data_out = 8'h00;
        if (lcd_data_oe) begin
            if (!lcd_rs) lcd_data_out = {busy, ac_q};
            else if (visible(ac_q)) lcd_data_out = ddram_q[{ac_q[6], ac_q[3:0]}];
            else lcd_data_out = 8'h20;
        end
    end

    assign busy      = (busy_cnt_q != 12'd0);
    assign ac        = ac_q;
    assign disp_on   = disp_on_q;
    assign err       = err_q;
    assign cmd_count = cmd_count_q;
    assign rd_char   = ddram_q[rd_addr];

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed bench for lcd_hd44780_responder: bus writes/reads with hand-computed expectations.
module tb_lcd_hd44780_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lcd_rs = 1'b0;
    logic        lcd_rw = 1'b0;
    logic        lcd_en = 1'b0;
    logic [7:0]  lcd_data_in = 8'h00;
    logic [7:0]  lcd_data_out;
    logic        lcd_data_oe;
    logic        busy;
    logic [6:0]  ac;
    logic        disp_on;
    logic [3:0]  err;
    logic [15:0] cmd_count;
    logic [4:0]  rd_addr = 5'd0;
    logic [7:0]  rd_char;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_ram [32];

    lcd_hd44780_responder #(.BUSY_CYCLES(40), .CLEAR_CYCLES(1600)) dut (
        .clk(clk), .rst(rst), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
        .lcd_data_in(lcd_data_in), .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe),
        .busy(busy), .ac(ac), .disp_on(disp_on), .err(err), .cmd_count(cmd_count),
        .rd_addr(rd_addr), .rd_char(rd_char)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wr(input logic rs, input logic [7:0] d);
        lcd_rs = rs; lcd_rw = 1'b0; lcd_data_in = d; lcd_en = 1'b1;
        tick();
        lcd_en = 1'b0;
        tick();
    endtask

    task automatic rd(input logic rs, output logic [7:0] v, output logic oe);
        lcd_rs = rs; lcd_rw = 1'b1; lcd_en = 1'b1;
        #1;
        v = lcd_data_out; oe = lcd_data_oe;
        tick();
        lcd_en = 1'b0;
        tick();
        lcd_rw = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 2000) begin tick(); n++; end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic wr_idle(input logic rs, input logic [7:0] d);
        wr(rs, d);
        wait_idle("idle");
    endtask

    task automatic check_ram(input string tag);
        for (int i = 0; i < 32; i++) begin
            rd_addr = 5'(i);
            #1;
            check(tag, {24'd0, rd_char}, {24'd0, exp_ram[i]});
        end
    endtask

    initial begin
        logic [7:0] v;
        logic oe;
        int n;
        for (int i = 0; i < 32; i++) exp_ram[i] = 8'h20;

        // Reset state
        tick(); tick();
        rst = 1'b1;
        tick();
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_ac", {25'd0, ac}, 0);
        check("rst_err", {28'd0, err}, 0);
        check("rst_cmd", {16'd0, cmd_count}, 0);
        check("rst_disp", {31'd0, disp_on}, 0);
        check("rst_oe", {31'd0, lcd_data_oe}, 0);
        check("rst_dout", {24'd0, lcd_data_out}, 0);
        check_ram("rst_ram");

        // Init sequence; measure ordinary and clear busy lengths
        wr(1'b0, 8'h38);
        n = 0;
        while (busy && n < 2000) begin tick(); n++; end
        check("busy_len_40", n, 40);
        wr_idle(1'b0, 8'h0C);
        wr_idle(1'b0, 8'h06);
        wr(1'b0, 8'h01);
        n = 0;
        while (busy && n < 2000) begin tick(); n++; end
        check("busy_len_1600", n, 1600);
        check("init_err", {28'd0, err}, 0);
        check("init_disp", {31'd0, disp_on}, 1);
        check("init_cmd", {16'd0, cmd_count}, 4);

        // Line wrap 0x0F -> 0x40 on data writes
        wr_idle(1'b0, 8'h8E);
        wr_idle(1'b1, 8'h41);
        wr_idle(1'b1, 8'h42);
        wr_idle(1'b1, 8'h43);
        exp_ram[14] = 8'h41; exp_ram[15] = 8'h42; exp_ram[16] = 8'h43;
        check("wrap_ac", {25'd0, ac}, 32'h41);
        check_ram("wrap_ram");
        check("wrap_cmd", {16'd0, cmd_count}, 8);

        // Data read returns DDRAM[ac] and steps ac
        wr_idle(1'b0, 8'h8E);
        rd(1'b1, v, oe);
        check("rd_data", {24'd0, v}, 32'h41);
        check("rd_oe", {31'd0, oe}, 1);
        check("rd_ac_step", {25'd0, ac}, 32'h0F);

        // Write while busy is rejected; status read shows busy
        wr(1'b0, 8'h80);
        repeat (10) tick();
        wr(1'b0, 8'h8A);
        check("busy_rej_cmd", {16'd0, cmd_count}, 10);
        check("busy_rej_ac", {25'd0, ac}, 0);
        check("busy_rej_err", {28'd0, err}, 32'h1);
        rd(1'b0, v, oe);
        check("status_rd", {24'd0, v}, 32'h80);
        wait_idle("idle_after_status");

        // Counter=1 at commit rejected, counter=0 accepted
        wr(1'b0, 8'h80);
        repeat (38) tick();
        wr(1'b0, 8'h85);
        check("cnt1_rej_cmd", {16'd0, cmd_count}, 11);
        check("cnt1_rej_ac", {25'd0, ac}, 0);
        wr(1'b0, 8'h85);
        check("cnt0_acc_cmd", {16'd0, cmd_count}, 12);
        check("cnt0_acc_ac", {25'd0, ac}, 5);
        wait_idle("idle_after_cnt0");

        // Out-of-range DDRAM access
        wr_idle(1'b0, 8'hA0);
        wr_idle(1'b1, 8'h58);
        check("oor_ac", {25'd0, ac}, 32'h21);
        check("oor_err", {28'd0, err}, 32'h5);
        check_ram("oor_ram");

        // Decrement mode wraps 0x00 -> 0x4F
        wr_idle(1'b0, 8'h04);
        wr_idle(1'b0, 8'h80);
        wr_idle(1'b1, 8'h5A);
        exp_ram[0] = 8'h5A;
        check("dec_ac", {25'd0, ac}, 32'h4F);
        check("dec_err", {28'd0, err}, 32'h5);
        check("dec_cmd", {16'd0, cmd_count}, 17);
        check_ram("dec_ram");

        // Reset during clear busy
        wr(1'b0, 8'h01);
        repeat (100) tick();
        check("clr_busy", {31'd0, busy}, 1);
        rst = 1'b0;
        tick();
        check("rst_mid_busy", {31'd0, busy}, 0);
        rst = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) exp_ram[i] = 8'h20;
        check("rst2_ac", {25'd0, ac}, 0);
        check("rst2_err", {28'd0, err}, 0);
        check("rst2_cmd", {16'd0, cmd_count}, 0);
        check_ram("rst2_ram");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
